// File: rtl/decoder_pkg.sv
// Shared types for the n-to-2^n sequenced decoder.
// Scan mode is compiled in with DECODER_SCAN_EN.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_nto2n_seq_scan_counter.sv
// Scan position / dwell counter; presents next index and wrap
// so the top can register them alongside y.
module scan_counter #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   pos_d,
  output logic               wrap_d
);

  logic [SEL_W-1:0]   pos;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    pos_d  = pos;
    cnt_d  = cnt;
    wrap_d = 1'b0;
    if (start) begin
      pos_d = '0;
      cnt_d = dwell;
    end else if (run) begin
      if (cnt != '0) begin
        cnt_d = cnt - DWELL_W'(1);
      end else begin
        pos_d  = pos + SEL_W'(1);
        cnt_d  = dwell;
        wrap_d = (pos == {SEL_W{1'b1}});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      cnt <= '0;
    end else begin
      pos <= pos_d;
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with handshake and
// optional scan mode (DECODER_SCAN_EN).
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  state_t           state;
  logic             scan_mode;
  logic [SEL_W-1:0] pos_d;
  logic             wrap_d;

`ifdef DECODER_SCAN_EN
  logic start;
  logic run;

  assign scan_mode = (mode == MODE_SCAN);
  assign start     = en & scan_mode & (state != SCAN);
  assign run       = en & scan_mode & (state == SCAN);

  scan_counter #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .run    (run),
    .dwell  (dwell),
    .pos_d  (pos_d),
    .wrap_d (wrap_d)
  );
`else
  wire unused_scan = ^{mode, dwell};

  assign scan_mode = 1'b0;
  assign pos_d     = '0;
  assign wrap_d    = 1'b0;
`endif

  assign sel_ready = en & ~scan_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y       <= '0;
      y_valid <= 1'b0;
      idx     <= '0;
      wrap    <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      y       <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (scan_mode) begin
      state   <= SCAN;
      y       <= ONE << pos_d;
      idx     <= pos_d;
      y_valid <= 1'b1;
      wrap    <= wrap_d;
    end else begin
      state <= DIRECT;
      wrap  <= 1'b0;
      if (sel_valid) begin
        y       <= ONE << sel;
        idx     <= sel;
        y_valid <= 1'b1;
      end else if (state != DIRECT) begin
        // leaving SCAN: blank until the first accepted code
        y       <= '0;
        y_valid <= 1'b0;
      end
    end
  end

endmodule
